// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   state_t : loader FSM state encodings
//   LEN_W   : width of the word-count header that precedes the image
package imem_loader_pkg;

  localparam int LEN_W = 16;

  typedef enum logic [1:0] {
    ST_LEN_HI = 2'd0,
    ST_LEN_LO = 2'd1,
    ST_DATA   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a byte stream into big-endian 32-bit words.
//   clk, rst   : clock, synchronous active-high reset
//   clear      : synchronous restart, drops any partial word
//   byte_en    : byte_in is consumed this cycle
//   byte_in    : stream byte, the first byte of a word lands in word[31:24]
//   word_valid : combinational pulse, the 4th byte of a word is being consumed now
//   word       : completed word, valid while word_valid is high
module imem_loader_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt_r;
  logic [23:0] shift_r;

  // Byte counter and shift register; only the three oldest bytes need storing
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= 2'd0;
      shift_r <= 24'd0;
    end else if (clear) begin
      cnt_r   <= 2'd0;
      shift_r <= 24'd0;
    end else if (byte_en) begin
      cnt_r   <= cnt_r + 2'd1;
      shift_r <= {shift_r[15:0], byte_in};
    end else begin
      cnt_r   <= cnt_r;
      shift_r <= shift_r;
    end
  end

  assign word_valid = byte_en && (cnt_r == 2'd3);
  assign word       = {shift_r, byte_in};

endmodule

// File: rtl/imem_loader.sv
// Boot loader for the instruction memory. Takes a byte stream carrying a 16-bit
// word count N (high byte first) followed by N big-endian words, writes the words
// to consecutive im addresses from 0 and holds the CPU in reset until done.
//   clk, rst          : clock, synchronous active-high reset
//   in_data/in_valid  : stream byte and its valid
//   in_ready          : loader can accept a byte (low only once the image is in)
//   start             : reload pulse, honoured only after the image is loaded
//   im_we/addr/wdata  : registered im write port, one strobe per word
//   cpu_rst           : CPU reset, high while loading
//   done              : image loaded
//   err               : N exceeded the im depth (sticky until rst/start)
//   words_loaded      : number of words actually written to im
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              start,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  // Depth expressed at index width and at length width (one extra bit for the compare)
  localparam logic [ADDR_W:0] DEPTH_IDX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [LEN_W:0]  DEPTH_LEN = (LEN_W + 1)'(DEPTH_IDX);

  state_t             state_r, state_next;
  logic [7:0]         len_hi_r, len_hi_next;
  logic [LEN_W-1:0]   rem_r, rem_next;
  logic [ADDR_W:0]    idx_r, idx_next;
  logic               last_r, last_next;
  logic               we_r, we_next;
  logic [ADDR_W-1:0]  addr_r, addr_next;
  logic [31:0]        wdata_r, wdata_next;
  logic               done_r, done_next;
  logic               err_r, err_next;
  logic               cpu_rst_r;

  logic               accept_s;
  logic [LEN_W-1:0]   len_s;
  logic               reload_s;
  logic               word_valid_s;
  logic [31:0]        word_s;

  assign in_ready = (state_r != ST_DONE);
  assign accept_s = in_valid && in_ready;
  assign len_s    = {len_hi_r, in_data};
  assign reload_s = (state_r == ST_DONE) && start;

  imem_loader_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (reload_s),
    .byte_en    (accept_s && (state_r == ST_DATA)),
    .byte_in    (in_data),
    .word_valid (word_valid_s),
    .word       (word_s)
  );

  // Next-state and next-output logic for the loader FSM and its counters
  always_comb begin
    state_next  = state_r;
    len_hi_next = len_hi_r;
    rem_next    = rem_r;
    idx_next    = idx_r;
    last_next   = 1'b0;
    we_next     = 1'b0;
    addr_next   = addr_r;
    wdata_next  = wdata_r;
    done_next   = done_r;
    err_next    = err_r;
    case (state_r)
      ST_LEN_HI: begin
        if (accept_s) begin
          len_hi_next = in_data;
          state_next  = ST_LEN_LO;
        end else begin
          state_next  = ST_LEN_HI;
        end
      end
      ST_LEN_LO: begin
        if (accept_s) begin
          rem_next = len_s;
          if (len_s == {LEN_W{1'b0}}) begin
            state_next = ST_DONE;
            done_next  = 1'b1;
          end else begin
            state_next = ST_DATA;
          end
          if ({1'b0, len_s} > DEPTH_LEN) begin
            err_next = 1'b1;
          end else begin
            err_next = err_r;
          end
        end else begin
          state_next = ST_LEN_LO;
        end
      end
      ST_DATA: begin
        if (word_valid_s) begin
          rem_next = rem_r - {{(LEN_W-1){1'b0}}, 1'b1};
          // Words beyond the im depth are swallowed; the index saturates so it never wraps to 0
          if (idx_r < DEPTH_IDX) begin
            we_next    = 1'b1;
            addr_next  = idx_r[ADDR_W-1:0];
            wdata_next = word_s;
            idx_next   = idx_r + {{ADDR_W{1'b0}}, 1'b1};
          end else begin
            we_next    = 1'b0;
          end
          if (rem_r == {{(LEN_W-1){1'b0}}, 1'b1}) begin
            state_next = ST_DONE;
            last_next  = 1'b1;
          end else begin
            state_next = ST_DATA;
          end
        end else begin
          state_next = ST_DATA;
        end
      end
      ST_DONE: begin
        // done trails the final write strobe by one cycle
        if (last_r) begin
          done_next = 1'b1;
        end else begin
          done_next = done_r;
        end
        if (start) begin
          state_next = ST_LEN_HI;
          done_next  = 1'b0;
          err_next   = 1'b0;
          idx_next   = {(ADDR_W+1){1'b0}};
          rem_next   = {LEN_W{1'b0}};
          last_next  = 1'b0;
        end else begin
          state_next = ST_DONE;
        end
      end
      default: begin
        state_next = ST_LEN_HI;
      end
    endcase
  end

  // State and output registers; cpu_rst is computed from done_next so it falls with done
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_LEN_HI;
      len_hi_r  <= 8'd0;
      rem_r     <= {LEN_W{1'b0}};
      idx_r     <= {(ADDR_W+1){1'b0}};
      last_r    <= 1'b0;
      we_r      <= 1'b0;
      addr_r    <= {ADDR_W{1'b0}};
      wdata_r   <= 32'd0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      cpu_rst_r <= 1'b1;
    end else begin
      state_r   <= state_next;
      len_hi_r  <= len_hi_next;
      rem_r     <= rem_next;
      idx_r     <= idx_next;
      last_r    <= last_next;
      we_r      <= we_next;
      addr_r    <= addr_next;
      wdata_r   <= wdata_next;
      done_r    <= done_next;
      err_r     <= err_next;
      cpu_rst_r <= ~done_next;
    end
  end

  assign im_we        = we_r;
  assign im_addr      = addr_r;
  assign im_wdata     = wdata_r;
  assign done         = done_r;
  assign err          = err_r;
  assign cpu_rst      = cpu_rst_r;
  assign words_loaded = idx_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (ADDR_W = 10).
module tb_imem_loader;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        in_data = 8'd0;
  logic              in_valid = 1'b0;
  logic              start = 1'b0;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_rst;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  int errors = 0;
  int checks = 0;

  logic [ADDR_W-1:0] wr_addr [0:2047];
  logic [31:0]       wr_data [0:2047];
  int                wr_cnt = 0;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .start        (start),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .cpu_rst      (cpu_rst),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  // Record every im write just after the edge that produced it
  always @(posedge clk) begin
    #1;
    if (im_we === 1'b1) begin
      if (wr_cnt < 2048) begin
        wr_addr[wr_cnt] = im_addr;
        wr_data[wr_cnt] = im_wdata;
      end
      wr_cnt = wr_cnt + 1;
    end
  end

  // Called at a negedge; returns at the negedge after the byte was accepted
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int k;
    in_data  = b;
    in_valid = 1'b1;
    k = 0;
    while (in_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (in_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_byte_ready: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (gap) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wr_cnt = 0;
  endtask

  task automatic send_image2(input bit gap);
    logic [7:0] s [0:9];
    s = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h10, 8'h01, 8'h00, 8'h00, 8'h00, 8'h08};
    for (int i = 0; i < 10; i++) send_byte(s[i], gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({in_ready, cpu_rst, done, im_we, err} !== 5'b11000 || words_loaded !== 11'd0) begin
      errors++;
      $display("FAIL reset: ready/cpu_rst/done/we/err=%b wl=%0d required 11000 wl=0",
               {in_ready, cpu_rst, done, im_we, err}, words_loaded);
    end
  endtask

  task automatic test_basic();
    do_reset();
    send_image2(1'b0);
    checks++;
    if (im_we !== 1'b1 || im_addr !== 10'd1 || im_wdata !== 32'h00000008 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_last_write: we=%b addr=%0d data=%h done=%b required 1 1 00000008 0",
               im_we, im_addr, im_wdata, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || cpu_rst !== 1'b0 || in_ready !== 1'b0 || im_we !== 1'b0 || words_loaded !== 11'd2) begin
      errors++;
      $display("FAIL basic_done: done=%b cpu_rst=%b ready=%b we=%b wl=%0d required 1 0 0 0 2",
               done, cpu_rst, in_ready, im_we, words_loaded);
    end
    checks++;
    if (wr_cnt !== 2 || wr_addr[0] !== 10'd0 || wr_data[0] !== 32'h3C011001 ||
        wr_addr[1] !== 10'd1 || wr_data[1] !== 32'h00000008) begin
      errors++;
      $display("FAIL basic_writes: n=%0d a0=%0d d0=%h a1=%0d d1=%h required 2 0 3c011001 1 00000008",
               wr_cnt, wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    send_byte(8'h00, 1'b0);
    checks++;
    if (done !== 1'b0 || cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL zero_len_early: done=%b cpu_rst=%b required 0 1", done, cpu_rst);
    end
    send_byte(8'h00, 1'b0);
    checks++;
    if (done !== 1'b1 || cpu_rst !== 1'b0 || in_ready !== 1'b0 || words_loaded !== 11'd0) begin
      errors++;
      $display("FAIL zero_len_done: done=%b cpu_rst=%b ready=%b wl=%0d required 1 0 0 0",
               done, cpu_rst, in_ready, words_loaded);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_cnt !== 0) begin
      errors++;
      $display("FAIL zero_len_writes: writes=%0d required 0", wr_cnt);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    send_image2(1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (wr_cnt !== 2 || wr_addr[0] !== 10'd0 || wr_data[0] !== 32'h3C011001 ||
        wr_addr[1] !== 10'd1 || wr_data[1] !== 32'h00000008) begin
      errors++;
      $display("FAIL gaps_writes: n=%0d a0=%0d d0=%h a1=%0d d1=%h required 2 0 3c011001 1 00000008",
               wr_cnt, wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
    end
    checks++;
    if (done !== 1'b1 || cpu_rst !== 1'b0 || words_loaded !== 11'd2) begin
      errors++;
      $display("FAIL gaps_done: done=%b cpu_rst=%b wl=%0d required 1 0 2", done, cpu_rst, words_loaded);
    end
  endtask

  task automatic test_overflow();
    int bad;
    logic [15:0] w;
    do_reset();
    send_byte(8'h04, 1'b0);
    send_byte(8'h01, 1'b0);
    checks++;
    if (err !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL overflow_err: err=%b done=%b required 1 0", err, done);
    end
    for (int i = 0; i < 1025; i++) begin
      w = 16'(i);
      send_byte(w[15:8], 1'b0);
      send_byte(w[7:0], 1'b0);
      send_byte(8'hA5, 1'b0);
      send_byte(8'h5A, 1'b0);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (wr_cnt !== 1024 || words_loaded !== 11'd1024 || done !== 1'b1 || err !== 1'b1) begin
      errors++;
      $display("FAIL overflow_count: writes=%0d wl=%0d done=%b err=%b required 1024 1024 1 1",
               wr_cnt, words_loaded, done, err);
    end
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      w = 16'(i);
      if (wr_addr[i] !== 10'(i) || wr_data[i] !== {w, 16'hA55A}) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL overflow_data: bad_entries=%0d required 0 (last a=%0d d=%h)",
               bad, wr_addr[1023], wr_data[1023]);
    end
    pulse_start();
    checks++;
    if (err !== 1'b0 || done !== 1'b0 || cpu_rst !== 1'b1 || words_loaded !== 11'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL overflow_start: err=%b done=%b cpu_rst=%b wl=%0d ready=%b required 0 0 1 0 1",
               err, done, cpu_rst, words_loaded, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h3C, 1'b0);
    send_byte(8'h01, 1'b0);
    do_reset();
    checks++;
    if (words_loaded !== 11'd0 || im_we !== 1'b0 || in_ready !== 1'b1 || cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL midword_reset: wl=%0d we=%b ready=%b cpu_rst=%b required 0 0 1 1",
               words_loaded, im_we, in_ready, cpu_rst);
    end
    send_image2(1'b0);
    @(negedge clk);
    checks++;
    if (wr_cnt !== 2 || wr_addr[0] !== 10'd0 || wr_data[0] !== 32'h3C011001 ||
        wr_addr[1] !== 10'd1 || wr_data[1] !== 32'h00000008 || done !== 1'b1) begin
      errors++;
      $display("FAIL after_reset_writes: n=%0d a0=%0d d0=%h a1=%0d d1=%h done=%b required 2 0 3c011001 1 00000008 1",
               wr_cnt, wr_addr[0], wr_data[0], wr_addr[1], wr_data[1], done);
    end
    pulse_start();
    checks++;
    if (cpu_rst !== 1'b1 || done !== 1'b0 || words_loaded !== 11'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reload_start: cpu_rst=%b done=%b wl=%0d ready=%b required 1 0 0 1",
               cpu_rst, done, words_loaded, in_ready);
    end
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b0);
    @(negedge clk);
    checks++;
    if (wr_cnt !== 3 || wr_addr[2] !== 10'd0 || wr_data[2] !== 32'hDEADBEEF ||
        done !== 1'b1 || words_loaded !== 11'd1 || cpu_rst !== 1'b0) begin
      errors++;
      $display("FAIL reload_image: n=%0d a=%0d d=%h done=%b wl=%0d cpu_rst=%b required 3 0 deadbeef 1 1 0",
               wr_cnt, wr_addr[2], wr_data[2], done, words_loaded, cpu_rst);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_gaps();
    test_overflow();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
